button_conditioner: RTL
=======================

# button_conditioner

Front-end input stage for the crawling-display design. It synchronizes and debounces the board's raw active-low push-buttons and emits clean levels and single-cycle press pulses. It also provides a debounced RUN enable that toggles on each press of button 0. It sits directly upstream of the start/stop and crawl logic, so RUN replaces the raw ON_OFF key as their run/stop control.

## Interface
- N_BTN, default 2: number of buttons conditioned; legal range 1..8.
- DEBOUNCE_CYCLES, default 500000: stable cycles required to accept a change. This is 10 ms at 50 MHz. Minimum legal value is 2.
- RUN_INIT, default 0: value loaded into RUN at reset.
- CLK  input  1: system clock, 50 MHz.
- CLEAR  input  1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- BTN  input  N_BTN: raw push-buttons; active-low; asynchronous to CLK; may bounce.
- LEVEL  output  N_BTN: debounced button state; 1 = pressed.
- PRESS  output  N_BTN: one-cycle pulse on each accepted press.
- RELEASE  output  N_BTN: one-cycle pulse on each accepted release.
- RUN  output  1: toggle flip-flop driven by PRESS[0].

## Operation
- Each BTN bit goes through a 2-flop synchronizer. Both flops reset to 1 (released). S denotes the second flop's output.
- Each button has its own FSM and counter. Counter width is $clog2(DEBOUNCE_CYCLES). The counter saturates and never wraps.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Reset state is IDLE.
  - IDLE: if S=0, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT: if S=1, go to IDLE (bounce rejected, no pulse). Otherwise, if cnt=DEBOUNCE_CYCLES-1, go to HELD. Otherwise increment cnt.
  - HELD: if S=1, go to RELEASE_WAIT and set cnt=0.
  - RELEASE_WAIT: if S=0, go to HELD (no pulse). Otherwise, if cnt=DEBOUNCE_CYCLES-1, go to IDLE. Otherwise increment cnt.
- All outputs are registered.
  - LEVEL=1 exactly while in HELD or RELEASE_WAIT.
  - PRESS is high for exactly the one cycle following the PRESS_WAIT→HELD transition.
  - RELEASE is high for exactly the one cycle following the RELEASE_WAIT→IDLE transition.
- RUN inverts on the same clock edge at which PRESS[0] is registered high, so RUN and PRESS[0] change together.
- Buttons are fully independent. Simultaneous presses on several buttons produce simultaneous pulses.
- Reset asserted mid-operation (CLEAR=0) at any time does the following immediately and without waiting for CLK:
  - FSMs go to IDLE and counters go to 0.
  - Synchronizers go to 1.
  - LEVEL, PRESS and RELEASE go to 0.
  - RUN goes to RUN_INIT.
- Reset deassertion while a button is held low: the press is accepted after the normal debounce delay. It is not suppressed.

## Timing
- Reset values: LEVEL=0, PRESS=0, RELEASE=0, RUN=RUN_INIT.
- Press latency (D = DEBOUNCE_CYCLES): let BTN fall and stay low before edge 0.
  - S is low after edge 1.
  - The FSM enters PRESS_WAIT at edge 2.
  - The FSM enters HELD at edge D+2. PRESS, LEVEL and RUN update on that edge.
- Release latency is symmetric: LEVEL falls and RELEASE pulses at edge D+2 after BTN rises.
- A bounce pulse of any length shorter than D stable cycles produces no output change.
- There is no minimum gap between accepted events beyond the debounce window. The maximum accepted event rate is one per D+1 cycles per button.

## Structure
- Shared package btn_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - localparam DEFAULT_DEBOUNCE = 500000.
- Sub-module debounce_fsm handles one button: synchronizer, counter, FSM, and LEVEL/PRESS/RELEASE registers. It is instantiated N_BTN times in a generate loop.
- The top contains only the generate loop and the RUN toggle flop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, N_BTN=2 and RUN_INIT=0.
- Reset: hold CLEAR=0 with BTN=2'b00 → all outputs 0. Release CLEAR → LEVEL[1:0]=2'b11 and PRESS=2'b11 exactly 6 edges later; RUN=1.
- Clean press: BTN[0] falls and is held 20 cycles → PRESS[0] high exactly 1 cycle at edge 6; LEVEL[0]=1 from edge 6; RUN 0→1.
  - Then BTN[0] rises → RELEASE[0] is a 1-cycle pulse 6 edges later, LEVEL[0]=0, RUN stays 1.
- Bounce rejection: BTN[0] toggles low for 3 cycles, high for 1, low for 2, then high for 20 → no PRESS, LEVEL or RUN change.
- RUN toggling: three clean press/release cycles on BTN[0] → RUN sequence 1,0,1. Presses on BTN[1] leave RUN unchanged.
- Simultaneous: both BTN bits fall on the same cycle → PRESS=2'b11 on the same cycle, 6 edges later.
- Async reset mid-debounce: assert CLEAR=0 between edges while in PRESS_WAIT → outputs clear immediately without a CLK edge. After release with BTN still low, PRESS fires 6 edges later.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the button conditioner.
//   btn_state_t      : per-button debounce FSM state
//   DEFAULT_DEBOUNCE : 10 ms at 50 MHz
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE = 500000;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bus between the board keys and the conditioner.
//   BTN     : raw active-low keys (asynchronous, bouncing)
//   LEVEL   : debounced state, 1 = pressed
//   PRESS   : one-cycle pulse per accepted press
//   RELEASE : one-cycle pulse per accepted release
//   RUN     : run/stop toggle driven by button 0
// master = key/consumer side, slave = conditioner.
interface button_conditioner_if #(
  parameter int N_BTN = 2
);

  logic [N_BTN-1:0] BTN;
  logic [N_BTN-1:0] LEVEL;
  logic [N_BTN-1:0] PRESS;
  logic [N_BTN-1:0] RELEASE;
  logic             RUN;

  modport master (output BTN, input LEVEL, input PRESS, input RELEASE, input RUN);
  modport slave  (input BTN, output LEVEL, output PRESS, output RELEASE, output RUN);

endinterface

// File: rtl/button_conditioner_debounce_fsm.sv
// One-button conditioner: 2-flop synchronizer, saturating stability counter,
// debounce FSM and registered level/pulse outputs.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   btn_i         : raw active-low key
//   level_o       : debounced state (1 = pressed)
//   press_o       : one-cycle pulse after an accepted press
//   release_o     : one-cycle pulse after an accepted release
//   press_nxt_o   : value press_o takes at the next edge (lets the RUN flop
//                   toggle on the same edge PRESS rises)
module debounce_fsm
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic press_nxt_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Synchronizer resets to "released" so a key held through reset is seen
  // as a fresh falling edge and still debounced normally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], btn_i};
  end

  assign s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Counter only advances below CNT_MAX, so it saturates rather than wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign press_nxt_o = press_d;

endmodule

// File: rtl/button_conditioner.sv
// Button front end: per-button debounce plus the RUN toggle that replaces
// the raw ON_OFF key for the start/stop and crawl logic.
//   CLK   : 50 MHz system clock
//   CLEAR : asynchronous active-low reset
//   bus   : slave side of the button bus (BTN in; LEVEL/PRESS/RELEASE/RUN out)
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter bit RUN_INIT        = 1'b0
) (
  input  logic                 CLK,
  input  logic                 CLEAR,
  button_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] press_nxt_w;
  logic             run_q, run_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    debounce_fsm #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fsm (
      .clk_i      (CLK),
      .rst_ni     (CLEAR),
      .btn_i      (bus.BTN[g]),
      .level_o    (level_w[g]),
      .press_o    (press_w[g]),
      .release_o  (release_w[g]),
      .press_nxt_o(press_nxt_w[g])
    );
  end

  // Toggle on the next-state of PRESS[0] so RUN and PRESS[0] change together.
  assign run_d = run_q ^ press_nxt_w[0];

  always_ff @(posedge CLK or negedge CLEAR) begin
    if (!CLEAR) run_q <= RUN_INIT;
    else        run_q <= run_d;
  end

  assign bus.LEVEL   = level_w;
  assign bus.PRESS   = press_w;
  assign bus.RELEASE = release_w;
  assign bus.RUN     = run_q;

endmodule
